branch_resolve_unit: RTL

//  Execute-stage producer of the taken_info / valid_taken_info update stream

---
 rtl/branch_resolve_unit_if.sv | 64 ++++++
 rtl/branch_resolve_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//   Bundles the fetch-side prediction push, the EX-stage branch operands and
//   the registered resolution / redirect outputs of branch_resolve_unit.
//   Optional macro BRANCH_STATS_EN adds the stat_branches / stat_mispredicts
//   counters to the bundle.
// Signals
//   pred_push, pred_taken   fetch pushes a predicted direction
//   pred_ready              queue can accept a push
//   ex_valid, ex_funct3     branch in EX and its condition code
//   ex_rs1, ex_rs2          branch operands (XLEN)
//   ex_pc, ex_imm           branch PC and sign-extended B-immediate (XLEN)
//   taken_info              resolved direction (held between updates)
//   valid_taken_info        one-cycle predictor update strobe
//   redirect_valid, flush   one-cycle mispredict strobe
//   redirect_pc             correct next PC after a mispredict
//   illegal_branch          one-cycle strobe for funct3 010/011
// Modports
//   master  drives fetch/EX inputs, observes results (pipeline side)
//   slave   the resolve unit itself
// ---------------------------------------------------------------------------
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            pred_push;
  logic            pred_taken;
  logic            pred_ready;
  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            taken_info;
  logic            valid_taken_info;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            illegal_branch;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output pred_push, pred_taken, ex_valid, ex_funct3,
           ex_rs1, ex_rs2, ex_pc, ex_imm,
    input  pred_ready, taken_info, valid_taken_info, redirect_valid,
           redirect_pc, flush, illegal_branch
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  pred_push, pred_taken, ex_valid, ex_funct3,
           ex_rs1, ex_rs2, ex_pc, ex_imm,
    output pred_ready, taken_info, valid_taken_info, redirect_valid,
           redirect_pc, flush, illegal_branch
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-stage branch resolver. Keeps a small FIFO of directions predicted
//   at fetch, resolves RV32I conditional branches in EX against the head of
//   that FIFO, and emits registered predictor-update and redirect strobes.
//   A mispredict clears the FIFO (all queued predictions are younger).
// Parameters
//   DEPTH  prediction FIFO entries (power of two, >= 2)
//   XLEN   operand / PC width
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    branch_resolve_if.slave (fetch push, EX operands, results)
// Configuration
//   BRANCH_STATS_EN  when defined, adds saturating 32-bit counters of legal
//                    resolutions and of mispredicts.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic               clk,
  input logic               reset,
  branch_resolve_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [DEPTH-1:0] pred_mem_q;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             taken_info_q, taken_info_d;
  logic             vld_q, redirect_q, illegal_q;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

  logic                   full, empty, legal, resolve, taken, predicted;
  logic                   mispredict, pop, push_ok;
  logic signed [XLEN-1:0] rs1_s, rs2_s;

  assign rs1_s   = bus.ex_rs1;
  assign rs2_s   = bus.ex_rs2;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // funct3 010/011 are the only reserved branch encodings.
  assign legal   = (bus.ex_funct3[2:1] != 2'b01);
  assign resolve = bus.ex_valid && legal;

  always_comb begin
    taken = 1'b0;
    unique case (bus.ex_funct3)
      F3_BEQ:  taken = (bus.ex_rs1 == bus.ex_rs2);
      F3_BNE:  taken = (bus.ex_rs1 != bus.ex_rs2);
      F3_BLT:  taken = (rs1_s <  rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (bus.ex_rs1 <  bus.ex_rs2);
      F3_BGEU: taken = (bus.ex_rs1 >= bus.ex_rs2);
      default: taken = 1'b0;
    endcase
  end

  // An empty queue means fetch never predicted this branch: treat as not taken.
  assign predicted  = empty ? 1'b0 : pred_mem_q[rd_ptr_q];
  assign mispredict = resolve && (taken != predicted);
  assign pop        = resolve && !empty;
  // Push acceptance looks only at full, never at a same-cycle pop.
  assign push_ok    = bus.pred_push && !full;

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    taken_info_d  = taken_info_q;
    redirect_pc_d = redirect_pc_q;
    if (resolve) taken_info_d = taken;
    if (mispredict) begin
      // Flush wins over any same-cycle push.
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      redirect_pc_d = taken ? bus.ex_pc + bus.ex_imm : bus.ex_pc + XLEN'(4);
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push_ok) count_d = count_q - CW'(1);
    end
  end

  // ---- queue storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push_ok && !mispredict) pred_mem_q[wr_ptr_q] <= bus.pred_taken;
  end

  // ---- EX -> registered outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      taken_info_q  <= 1'b0;
      vld_q         <= 1'b0;
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      taken_info_q  <= taken_info_d;
      vld_q         <= resolve;
      redirect_q    <= mispredict;
      illegal_q     <= bus.ex_valid && !legal;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.pred_ready       = !full;
  assign bus.taken_info       = taken_info_q;
  assign bus.valid_taken_info = vld_q;
  assign bus.redirect_valid   = redirect_q;
  assign bus.flush            = redirect_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.illegal_branch   = illegal_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= sat_inc(stat_br_q, resolve);
      stat_mp_q <= sat_inc(stat_mp_q, mispredict);
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`endif
endmodule
